// File: rtl/logic_op_arbiter.sv
// +--------------------------------------------------------------------------------+
// | logic_op_arbiter: two-requester arbiter for a shared 8-bit logic unit.          |
// | Optional: LOGIC_ARB_ACCUM_EN adds a result accumulator and chain ports. Rev 1.0 |
// +--------------------------------------------------------------------------------+
`default_nettype none

module logic_op_unit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] and_o,
  output logic [7:0] or_o,
  output logic [7:0] nand_o,
  output logic [7:0] nor_o,
  output logic [7:0] xor_o,
  output logic [7:0] xnor_o
);
  assign and_o  = a_i & b_i;
  assign or_o   = a_i | b_i;
  assign nand_o = ~(a_i & b_i);
  assign nor_o  = ~(a_i | b_i);
  assign xor_o  = a_i ^ b_i;
  assign xnor_o = ~(a_i ^ b_i);
endmodule

module logic_op_arbiter #(
  parameter int PRIO_FIXED  = 0,
  parameter int STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
`ifdef LOGIC_ARB_ACCUM_EN
  input  logic       req0_chain,
  input  logic       req1_chain,
`endif
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic       rsp_id,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic       stall_err
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] C_STALL_LIM = 8'(STALL_LIMIT);

  state_e     state_q;
  logic       last_grant_q;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       id_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_y_q;
  logic       rsp_id_q;
  logic       rsp_zero_q;
  logic       rsp_err_q;
  logic       stall_err_q;
  logic [7:0] stall_cnt_q;
  logic [7:0] stall_cnt_d;

  logic       w_grant_any;
  logic       w_grant_id;
  logic [7:0] w_sel_a;
  logic [7:0] w_and, w_or, w_nand, w_nor, w_xor, w_xnor;
  logic [7:0] w_y;
  logic       w_err;

  // On a tie, round-robin favours whoever did not win the last transfer.
  always_comb begin
    w_grant_any = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    if (req0_valid && req1_valid)
      w_grant_id = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q;
    else
      w_grant_id = req1_valid;
  end

  assign req0_ready = w_grant_any && !w_grant_id;
  assign req1_ready = w_grant_any && w_grant_id;

`ifdef LOGIC_ARB_ACCUM_EN
  logic [7:0] acc_q;
  assign w_sel_a = w_grant_id ? (req1_chain ? acc_q : req1_a)
                              : (req0_chain ? acc_q : req0_a);
`else
  assign w_sel_a = w_grant_id ? req1_a : req0_a;
`endif

  logic_op_unit u_unit (
    .a_i    (a_q),
    .b_i    (b_q),
    .and_o  (w_and),
    .or_o   (w_or),
    .nand_o (w_nand),
    .nor_o  (w_nor),
    .xor_o  (w_xor),
    .xnor_o (w_xnor)
  );

  always_comb begin
    w_y   = 8'h00;
    w_err = 1'b0;
    case (op_q)
      3'd0:    w_y = w_and;
      3'd1:    w_y = w_or;
      3'd2:    w_y = w_nand;
      3'd3:    w_y = w_nor;
      3'd4:    w_y = w_xor;
      3'd5:    w_y = w_xnor;
      default: w_err = 1'b1;
    endcase
  end

  assign stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 3'd0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= 8'h00;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      stall_err_q  <= 1'b0;
      stall_cnt_q  <= 8'h00;
`ifdef LOGIC_ARB_ACCUM_EN
      acc_q        <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_grant_any) begin
            op_q         <= w_grant_id ? req1_op : req0_op;
            a_q          <= w_sel_a;
            b_q          <= w_grant_id ? req1_b : req0_b;
            id_q         <= w_grant_id;
            last_grant_q <= w_grant_id;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y_q     <= w_y;
          rsp_zero_q  <= (w_y == 8'h00);
          rsp_err_q   <= w_err;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            stall_cnt_q <= 8'h00;
`ifdef LOGIC_ARB_ACCUM_EN
            acc_q       <= rsp_y_q;
`endif
            state_q     <= ST_IDLE;
          end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stall_cnt_d >= C_STALL_LIM)
              stall_err_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign stall_err = stall_err_q;
endmodule

`default_nettype wire
